// File: rtl/ram_stream_loader.sv
// Loads a valid/ready word stream into a single-port RAM, keeps a running checksum and
// optionally reads the block back to confirm the sum.
module ram_stream_loader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  input  logic              verify_en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  // The RAM holds 2^(ADDR_W-1) words; the address MSB is never driven.
  localparam int unsigned PW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] MaxCount = {1'b1, {PW{1'b0}}};
  localparam logic [PW-1:0]     AddrOne  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CntOne   = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     addr_q, addr_d;
  logic [PW-1:0]     base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              vfy_q, vfy_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] cnt_clamped;
  logic [DATA_W-1:0] rd_sum;
  logic              unused_base_msb;

  assign unused_base_msb = base[ADDR_W-1];
  assign cnt_clamped     = (count > MaxCount) ? MaxCount : count;
  assign rd_sum          = rsum_q + ram_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      vfy_q   <= 1'b0;
      csum_q  <= '0;
      rsum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      vfy_q   <= vfy_d;
      csum_q  <= csum_d;
      rsum_q  <= rsum_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    base_d   = base_q;
    len_d    = len_q;
    rem_d    = rem_q;
    vfy_d    = vfy_q;
    csum_d   = csum_q;
    rsum_d   = rsum_q;
    err_d    = err_q;
    s_ready  = 1'b0;
    ram_ld   = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    busy     = 1'b0;
    done     = 1'b0;

    // Outputs are forced low while reset is asserted so an abort never writes.
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_d  = base[PW-1:0];
            addr_d  = base[PW-1:0];
            len_d   = cnt_clamped;
            rem_d   = cnt_clamped;
            vfy_d   = verify_en;
            csum_d  = '0;
            rsum_d  = '0;
            err_d   = 1'b0;
            state_d = (cnt_clamped == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          s_ready  = 1'b1;
          ram_ld   = s_valid;
          ram_addr = {1'b0, addr_q};
          ram_in   = s_data;
          busy     = 1'b1;
          if (s_valid) begin
            csum_d = csum_q + s_data;
            addr_d = addr_q + AddrOne;
            rem_d  = rem_q - CntOne;
            if (rem_q == CntOne) begin
              if (vfy_q) begin
                state_d = StVerify;
                addr_d  = base_q;
                rem_d   = len_q;
                rsum_d  = '0;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
        StVerify: begin
          ram_addr = {1'b0, addr_q};
          busy     = 1'b1;
          rsum_d   = rd_sum;
          addr_d   = addr_q + AddrOne;
          rem_d    = rem_q - CntOne;
          if (rem_q == CntOne) begin
            err_d   = (rd_sum != csum_q);
            state_d = StDone;
          end
        end
        StDone: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign checksum = rst_n ? csum_q : '0;
  assign err      = rst_n & err_q;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Self-checking bench: RAM model, transaction-level reference model and per-cycle compare.
module tb_ram_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] base;
  logic [14:0] count;
  logic        verify_en;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [14:0] ram_addr;
  logic [15:0] ram_in;
  logic        ram_ld;
  logic [15:0] ram_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  int errors = 0;
  int checks = 0;

  ram_stream_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .count    (count),
    .verify_en(verify_en),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .ram_addr (ram_addr),
    .ram_in   (ram_in),
    .ram_ld   (ram_ld),
    .ram_out  (ram_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // RAM model with optional read corruption at one address
  logic [15:0] ram [0:16383];
  logic        ram_clr;
  logic        corrupt_en;
  int          corrupt_addr;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= 16'h0;
    end else if (ram_ld) begin
      ram[ram_addr[13:0]] <= ram_in;
    end
  end

  assign ram_out = ram[ram_addr[13:0]] ^
                   ((corrupt_en && int'(ram_addr) == corrupt_addr) ? 16'h8001 : 16'h0000);

  // Reference model: phase 0 idle, 1 load, 2 verify, 3 done
  logic [15:0] m_mem [0:16383];
  int          m_phase, m_idx, m_len, m_base;
  logic        m_vfy, m_err;
  logic [15:0] m_sum, m_rsum;

  function automatic logic [15:0] m_read(input int a);
    return m_mem[a] ^ ((corrupt_en && a == corrupt_addr) ? 16'h8001 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 16384; i++) m_mem[i] = 16'h0;
    end
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_len = 0; m_base = 0;
      m_vfy = 1'b0; m_err = 1'b0; m_sum = 16'h0; m_rsum = 16'h0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_base  = int'(base) % 16384;
          m_len   = (int'(count) > 16384) ? 16384 : int'(count);
          m_vfy   = verify_en;
          m_sum   = 16'h0;
          m_err   = 1'b0;
          m_idx   = 0;
          m_phase = (m_len == 0) ? 3 : 1;
        end
        1: if (s_valid) begin
          m_mem[(m_base + m_idx) % 16384] = s_data;
          m_sum = m_sum + s_data;
          m_idx++;
          if (m_idx == m_len) begin
            if (m_vfy) begin
              m_phase = 2; m_idx = 0; m_rsum = 16'h0;
            end else begin
              m_phase = 3;
            end
          end
        end
        2: begin
          m_rsum = m_rsum + m_read((m_base + m_idx) % 16384);
          m_idx++;
          if (m_idx == m_len) begin
            m_err   = (m_rsum != m_sum);
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  logic        chk_en;
  logic        e_rdy, e_ld, e_busy, e_done, e_err, chk_in;
  logic [14:0] e_addr;
  logic [15:0] e_in, e_cs;

  always @(negedge clk) begin
    if (chk_en) begin
      e_rdy = 0; e_ld = 0; e_addr = '0; e_in = '0; e_busy = 0; e_done = 0;
      e_cs = m_sum; e_err = m_err; chk_in = 1;
      if (!rst_n) begin
        e_cs = '0; e_err = 0;
      end else begin
        case (m_phase)
          1: begin
            e_rdy = 1; e_ld = s_valid; e_addr = 15'((m_base + m_idx) % 16384);
            e_in = s_data; e_busy = 1;
          end
          2: begin
            e_addr = 15'((m_base + m_idx) % 16384); e_busy = 1; chk_in = 0;
          end
          3: e_done = 1;
          default: ;
        endcase
      end
      check("s_ready", 32'(s_ready), 32'(e_rdy));
      check("ram_ld", 32'(ram_ld), 32'(e_ld));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (chk_in) check("ram_in", 32'(ram_in), 32'(e_in));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(e_err));
      check("checksum", 32'(checksum), 32'(e_cs));
    end
  end

  // Free-running event counters; tests take differences
  int n_ld = 0, n_busy = 0, n_done = 0;
  always @(negedge clk) begin
    if (ram_ld) n_ld++;
    if (busy) n_busy++;
    if (done) n_done++;
  end

  logic rnd_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [14:0] b, input logic [14:0] c, input logic v);
    start = 1'b1; base = b; count = c; verify_en = v;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d, input int gap);
    repeat (gap) begin
      s_valid = 1'b0; s_data = 16'($urandom);
      if (rnd_start) begin
        start = 1'($urandom_range(0, 1)); base = 15'($urandom); count = 15'($urandom);
      end
      tick();
    end
    s_valid = 1'b1; s_data = d;
    if (rnd_start) begin
      start = 1'($urandom_range(0, 1)); base = 15'($urandom); count = 15'($urandom);
    end
    tick();
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic [15:0] cs, output logic e,
                           output int cyc);
    logic found = 1'b0;
    cyc = 0; cs = '0; e = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        found = 1'b1; cs = checksum; e = err;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    tick();
  endtask

  logic [15:0] cs;
  logic        e;
  int          cyc, ld0, busy0, done0, len, b;

  initial begin
    rst_n = 0; start = 0; base = '0; count = '0; verify_en = 0; s_valid = 0; s_data = '0;
    ram_clr = 1; corrupt_en = 0; corrupt_addr = -1; chk_en = 0; rnd_start = 0;
    tick();
    ram_clr = 0;
    tick();
    chk_en = 1;
    @(negedge clk);
    check("reset_checksum", 32'(checksum), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1;
    tick();

    // Basic load with verify
    busy0 = n_busy;
    go(15'h0010, 15'd4, 1'b1);
    for (int i = 1; i <= 4; i++) feed(16'(i), 0);
    wait_done(20, cs, e, cyc);
    check("basic_checksum", 32'(cs), 32'h000A);
    check("basic_err", 32'(e), 32'h0);
    check("basic_busy_cycles", 32'(n_busy - busy0), 32'd8);
    for (int i = 0; i < 4; i++) check("basic_ram", 32'(ram[16 + i]), 32'(i + 1));

    // Address wrap
    go(15'h3FFE, 15'd3, 1'b1);
    feed(16'hFFFF, 0); feed(16'h0001, 0); feed(16'h1234, 0);
    wait_done(20, cs, e, cyc);
    check("wrap_checksum", 32'(cs), 32'h1234);
    check("wrap_err", 32'(e), 32'h0);
    check("wrap_ram_3ffe", 32'(ram[16'h3FFE]), 32'hFFFF);
    check("wrap_ram_3fff", 32'(ram[16'h3FFF]), 32'h0001);
    check("wrap_ram_0", 32'(ram[0]), 32'h1234);

    // Stall: valid 1,0,0,1
    ld0 = n_ld;
    go(15'h0020, 15'd2, 1'b0);
    feed(16'hAAAA, 0); feed(16'h5555, 2);
    wait_done(20, cs, e, cyc);
    check("stall_writes", 32'(n_ld - ld0), 32'd2);
    check("stall_ram_20", 32'(ram[16'h20]), 32'hAAAA);
    check("stall_ram_21", 32'(ram[16'h21]), 32'h5555);
    check("stall_checksum", 32'(cs), 32'hFFFF);

    // count = 0
    ld0 = n_ld;
    go(15'h0030, 15'd0, 1'b1);
    wait_done(5, cs, e, cyc);
    check("zero_done_latency", 32'(cyc), 32'd1);
    check("zero_writes", 32'(n_ld - ld0), 32'd0);
    check("zero_checksum", 32'(cs), 32'h0);

    // Verify mismatch; err sticky until next start
    corrupt_en = 1; corrupt_addr = 16'h0401;
    go(15'h0400, 15'd3, 1'b1);
    feed(16'h0102, 0); feed(16'h0304, 0); feed(16'h0506, 0);
    wait_done(20, cs, e, cyc);
    check("mismatch_err", 32'(e), 32'h1);
    repeat (3) tick();
    @(negedge clk);
    check("mismatch_err_sticky", 32'(err), 32'h1);
    tick();
    go(15'h0000, 15'd0, 1'b0);
    @(negedge clk);
    check("mismatch_err_cleared", 32'(err), 32'h0);
    tick();
    corrupt_en = 0; corrupt_addr = -1;

    // Reset mid-LOAD after 2 of 5 words
    done0 = n_done;
    go(15'h0200, 15'd5, 1'b1);
    feed(16'h1111, 0); feed(16'h2222, 0);
    s_valid = 1; s_data = 16'h3333; rst_n = 0;
    @(negedge clk);
    check("abort_ram_ld", 32'(ram_ld), 32'h0);
    check("abort_s_ready", 32'(s_ready), 32'h0);
    tick();
    rst_n = 1; s_valid = 0;
    repeat (6) tick();
    check("abort_no_done", 32'(n_done - done0), 32'd0);
    check("abort_ram_200", 32'(ram[16'h200]), 32'h1111);
    check("abort_ram_201", 32'(ram[16'h201]), 32'h2222);
    check("abort_ram_202", 32'(ram[16'h202]), 32'h0000);

    // start during LOAD is ignored
    ld0 = n_ld;
    go(15'h0300, 15'd3, 1'b0);
    feed(16'h0A0A, 0);
    start = 1; base = 15'h0050; count = 15'd9;
    feed(16'h0B0B, 0);
    feed(16'h0C0C, 0);
    wait_done(20, cs, e, cyc);
    check("ignore_writes", 32'(n_ld - ld0), 32'd3);
    check("ignore_checksum", 32'(cs), 32'h2121);
    check("ignore_ram_302", 32'(ram[16'h302]), 32'h0C0C);
    check("ignore_ram_50", 32'(ram[16'h50]), 32'h0000);

    // Count clamp; base MSB is ignored
    ld0 = n_ld;
    go(15'h7FFF, 15'h7FFF, 1'b0);
    for (int i = 0; i < 16384; i++) feed(16'(i), 0);
    wait_done(10, cs, e, cyc);
    check("clamp_writes", 32'(n_ld - ld0), 32'd16384);
    check("clamp_checksum", 32'(cs), 32'hE000);
    check("clamp_ram_3fff", 32'(ram[16'h3FFF]), 32'h0000);
    check("clamp_ram_0", 32'(ram[0]), 32'h0001);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      b   = int'($urandom_range(0, 32767));
      len = int'($urandom_range(0, 10));
      if (len > 0 && $urandom_range(0, 2) == 0) begin
        corrupt_en = 1; corrupt_addr = (b % 16384 + int'($urandom_range(0, len - 1))) % 16384;
      end
      go(15'(b), 15'(len), 1'($urandom_range(0, 1)));
      rnd_start = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) feed(16'($urandom), int'($urandom_range(0, 2)));
      rnd_start = 0;
      wait_done(40, cs, e, cyc);
      corrupt_en = 0; corrupt_addr = -1;
      repeat ($urandom_range(0, 2)) tick();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
